// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path. These include the segment
// pattern map (shared with the display encoder), the width constants, the
// receive state enum and the slot-select classifier.
package seg_pkg;

  localparam int unsigned NSLOT   = 8;
  localparam int unsigned NDIG    = 8;
  localparam int unsigned SEGW    = 8;
  localparam int unsigned NIBW    = 4;
  localparam int unsigned SLOTW   = 3;
  localparam int unsigned WORDW   = NDIG * NIBW;
  localparam int unsigned SEGBUSW = NDIG * SEGW;
  localparam int unsigned CNTW    = 16;

  // Segment patterns, bit 7 = segment a ... bit 1 = segment g, bit 0 = dp
  localparam logic [SEGW-1:0] SEG_0 = 8'hFC;
  localparam logic [SEGW-1:0] SEG_1 = 8'h60;
  localparam logic [SEGW-1:0] SEG_2 = 8'hDA;
  localparam logic [SEGW-1:0] SEG_3 = 8'hF2;
  localparam logic [SEGW-1:0] SEG_4 = 8'h66;
  localparam logic [SEGW-1:0] SEG_5 = 8'hB6;
  localparam logic [SEGW-1:0] SEG_6 = 8'hBE;
  localparam logic [SEGW-1:0] SEG_7 = 8'hE0;
  localparam logic [SEGW-1:0] SEG_8 = 8'hFE;
  localparam logic [SEGW-1:0] SEG_9 = 8'hF6;
  localparam logic [SEGW-1:0] SEG_A = 8'hEE;
  localparam logic [SEGW-1:0] SEG_B = 8'h3E;
  localparam logic [SEGW-1:0] SEG_C = 8'h1A;
  localparam logic [SEGW-1:0] SEG_D = 8'h7A;
  localparam logic [SEGW-1:0] SEG_E = 8'h9E;
  localparam logic [SEGW-1:0] SEG_F = 8'h8E;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Classified view of the slot-select bus
  typedef struct packed {
    logic             blank;
    logic             onehot;
    logic [SLOTW-1:0] slot;
  } sel_class_t;

  // The result is blank when no bit is set and onehot when exactly one bit is set.
  // slot is meaningful only when onehot is set.
  function automatic sel_class_t classify_sel(input logic [NSLOT-1:0] sel);
    sel_class_t c;
    c.blank  = (sel == '0);
    c.onehot = (sel != '0) && ((sel & (sel - NSLOT'(1))) == '0);
    c.slot   = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (sel[i]) c.slot = SLOTW'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Converts one 7-segment pattern back to its hex nibble.
// The decoder is purely combinational.
//   pattern_i  : segment byte as driven on the display bus
//   nibble_c_o : decoded nibble (0 when invalid)
//   valid_c_o  : pattern is one of the 16 legal glyphs
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [SEGW-1:0] pattern_i,
  output logic [NIBW-1:0] nibble_c_o,
  output logic            valid_c_o
);

  always_comb begin
    nibble_c_o = '0;
    valid_c_o  = 1'b1;
    case (pattern_i)
      SEG_0:   nibble_c_o = 4'h0;
      SEG_1:   nibble_c_o = 4'h1;
      SEG_2:   nibble_c_o = 4'h2;
      SEG_3:   nibble_c_o = 4'h3;
      SEG_4:   nibble_c_o = 4'h4;
      SEG_5:   nibble_c_o = 4'h5;
      SEG_6:   nibble_c_o = 4'h6;
      SEG_7:   nibble_c_o = 4'h7;
      SEG_8:   nibble_c_o = 4'h8;
      SEG_9:   nibble_c_o = 4'h9;
      SEG_A:   nibble_c_o = 4'hA;
      SEG_B:   nibble_c_o = 4'hB;
      SEG_C:   nibble_c_o = 4'hC;
      SEG_D:   nibble_c_o = 4'hD;
      SEG_E:   nibble_c_o = 4'hE;
      SEG_F:   nibble_c_o = 4'hF;
      default: valid_c_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_frame_decoder.sv
// Receive-side decoder for the 7-segment scan bus. It registers the rotating
// slot select and the segment bus, and decodes each slot back into a 32-bit word.
// A full in-order sweep of 8 slots is assembled into a frame, and only complete
// frames are committed to the read port.
//   clk, n_rst   : clock, asynchronous active-low reset
//   seg_out      : 64-bit segment bus, digit 7 in [63:56]
//   seg_sel      : one-hot slot select, 0 = blank
//   err_clr      : clears the sticky error flags
//   rd_addr      : slot index into the committed frame
//   rd_data      : committed word for rd_addr (combinational read)
//   frame_valid  : at least one frame committed
//   frame_done   : one-cycle pulse per commit
//   frame_cnt    : wrapping count of committed frames
//   seq_err, sel_err, dig_err : sticky order / select / pattern errors
module seg_frame_decoder
  import seg_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [SEGBUSW-1:0]   seg_out,
  input  logic [NSLOT-1:0]     seg_sel,
  input  logic                 err_clr,
  input  logic [SLOTW-1:0]     rd_addr,
  output logic [WORDW-1:0]     rd_data,
  output logic                 frame_valid,
  output logic                 frame_done,
  output logic [CNTW-1:0]      frame_cnt,
  output logic                 seq_err,
  output logic                 sel_err,
  output logic                 dig_err
);

  // Stage 1: unqualified input capture
  logic [SEGBUSW-1:0] seg_q;
  logic [NSLOT-1:0]   sel_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      seg_q <= '0;
      sel_q <= '0;
    end else begin
      seg_q <= seg_out;
      sel_q <= seg_sel;
    end
  end

  // Stage 2: parallel digit decode and select classification
  logic [WORDW-1:0] word_c;
  logic [NDIG-1:0]  dig_valid_c;
  sel_class_t       sel_c;
  logic             digits_ok_c;

  for (genvar g = 0; g < NDIG; g++) begin : g_dec
    seg_digit_decode u_dec (
      .pattern_i  (seg_q[g*SEGW +: SEGW]),
      .nibble_c_o (word_c[g*NIBW +: NIBW]),
      .valid_c_o  (dig_valid_c[g])
    );
  end

  assign sel_c       = classify_sel(sel_q);
  assign digits_ok_c = &dig_valid_c;

  // Frame assembly state
  state_e                        state_q, state_d;
  logic [SLOTW-1:0]              exp_q, exp_d;
  logic [NSLOT-1:0][WORDW-1:0]   work_q, work_d;
  logic [NSLOT-1:0][WORDW-1:0]   commit_q, commit_d;
  logic                          frame_valid_q, frame_valid_d;
  logic                          frame_done_q, frame_done_d;
  logic [CNTW-1:0]               frame_cnt_q, frame_cnt_d;
  logic                          seq_err_q, seq_err_d;
  logic                          sel_err_q, sel_err_d;
  logic                          dig_err_q, dig_err_d;

  logic                          wr_en_c;
  logic                          commit_c;
  logic                          seq_set_c;
  logic                          sel_set_c;
  logic                          dig_set_c;

  // Next-state logic: sequencing, working-buffer writes, commit and error flags
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    wr_en_c   = 1'b0;
    commit_c  = 1'b0;
    seq_set_c = 1'b0;
    sel_set_c = 1'b0;
    dig_set_c = 1'b0;

    if (!sel_c.blank && !sel_c.onehot) begin
      sel_set_c = 1'b1;
      state_d   = IDLE;
      exp_d     = '0;
    end else if (!sel_c.blank && !digits_ok_c) begin
      dig_set_c = 1'b1;
      state_d   = IDLE;
      exp_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!sel_c.blank && (sel_c.slot == '0)) begin
            wr_en_c = 1'b1;
            exp_d   = SLOTW'(1);
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (!sel_c.blank && (sel_c.slot == exp_q)) begin
            wr_en_c = 1'b1;
            if (exp_q == SLOTW'(NSLOT - 1)) begin
              commit_c = 1'b1;
              exp_d    = '0;
              state_d  = IDLE;
            end else begin
              exp_d = exp_q + SLOTW'(1);
            end
          end else begin
            seq_set_c = 1'b1;
            // A slot 0 here is the start of the next sweep, so no data is lost.
            if (!sel_c.blank && (sel_c.slot == '0)) begin
              wr_en_c = 1'b1;
              exp_d   = SLOTW'(1);
              state_d = COLLECT;
            end else begin
              exp_d   = '0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          exp_d   = '0;
          state_d = IDLE;
        end
      endcase
    end

    work_d = work_q;
    if (wr_en_c) work_d[sel_c.slot] = word_c;

    // The commit takes the working image including the slot-7 word written this cycle.
    commit_d      = commit_c ? work_d : commit_q;
    frame_valid_d = frame_valid_q | commit_c;
    frame_done_d  = commit_c;
    frame_cnt_d   = frame_cnt_q + CNTW'(commit_c);

    // When a clear and a new error arrive in the same cycle, the new error wins.
    seq_err_d = (seq_err_q & ~err_clr) | seq_set_c;
    sel_err_d = (sel_err_q & ~err_clr) | sel_set_c;
    dig_err_d = (dig_err_q & ~err_clr) | dig_set_c;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      exp_q         <= '0;
      work_q        <= '0;
      commit_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      seq_err_q     <= 1'b0;
      sel_err_q     <= 1'b0;
      dig_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      work_q        <= work_d;
      commit_q      <= commit_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      seq_err_q     <= seq_err_d;
      sel_err_q     <= sel_err_d;
      dig_err_q     <= dig_err_d;
    end
  end

  assign rd_data     = commit_q[rd_addr];
  assign frame_valid = frame_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign seq_err     = seq_err_q;
  assign sel_err     = sel_err_q;
  assign dig_err     = dig_err_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Testbench for seg_frame_decoder. It uses directed scenarios plus a randomized
// stream, and checks the results against a frame-level reference model.
module tb_seg_frame_decoder;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [63:0] seg_out;
  logic [7:0]  seg_sel;
  logic        err_clr;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        frame_valid;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        seq_err;
  logic        sel_err;
  logic        dig_err;

  always #5 clk = ~clk;

  seg_frame_decoder dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .seg_out     (seg_out),
    .seg_sel     (seg_sel),
    .err_clr     (err_clr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .seq_err     (seq_err),
    .sel_err     (sel_err),
    .dig_err     (dig_err)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] PAT [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                     8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

  // Reference model: a frame is a queue of words that grows only in slot order
  logic [31:0] m_frame [$];
  logic [31:0] m_commit [8];
  logic        m_valid, m_done, m_seq, m_sel, m_dig;
  logic [15:0] m_cnt;
  logic [7:0]  p_sel;
  logic [63:0] p_seg;

  function automatic logic [63:0] enc(input logic [31:0] w);
    logic [63:0] s;
    for (int d = 0; d < 8; d++) s[8*d +: 8] = PAT[w[4*d +: 4]];
    return s;
  endfunction

  function automatic logic [19:0] m_status();
    return {m_valid, m_seq, m_sel, m_dig, m_cnt};
  endfunction

  function automatic logic [19:0] d_status();
    return {frame_valid, seq_err, sel_err, dig_err, frame_cnt};
  endfunction

  task automatic model_reset();
    m_frame.delete();
    for (int i = 0; i < 8; i++) m_commit[i] = '0;
    m_valid = 0; m_done = 0; m_seq = 0; m_sel = 0; m_dig = 0; m_cnt = '0;
    p_sel = '0; p_seg = '0;
  endtask

  // Applies one registered (sel, seg) pair together with the err_clr level seen at the same edge.
  task automatic model_apply(input logic [7:0] sel, input logic [63:0] seg, input logic clr);
    logic ns, nq, nd, ok, found;
    logic [31:0] w;
    int s;
    ns = 0; nq = 0; nd = 0; ok = 1; w = '0; s = 0;
    m_done = 0;
    if ($countones(sel) > 1) begin
      ns = 1;
      m_frame.delete();
    end else if (sel == 8'h00) begin
      if (m_frame.size() > 0) nq = 1;
      m_frame.delete();
    end else begin
      for (int i = 0; i < 8; i++) if (sel[i]) s = i;
      for (int d = 0; d < 8; d++) begin
        found = 0;
        for (int n = 0; n < 16; n++) begin
          if (PAT[n] == seg[8*d +: 8]) begin
            w[4*d +: 4] = 4'(n);
            found = 1;
          end
        end
        if (!found) ok = 0;
      end
      if (!ok) begin
        nd = 1;
        m_frame.delete();
      end else if (s == m_frame.size()) begin
        m_frame.push_back(w);
        if (m_frame.size() == 8) begin
          for (int i = 0; i < 8; i++) m_commit[i] = m_frame[i];
          m_valid = 1;
          m_done  = 1;
          m_cnt   = m_cnt + 16'd1;
          m_frame.delete();
        end
      end else begin
        if (m_frame.size() > 0) nq = 1;
        m_frame.delete();
        if (s == 0) m_frame.push_back(w);
      end
    end
    if (clr) begin
      m_seq = 0; m_sel = 0; m_dig = 0;
    end
    m_seq = m_seq | nq;
    m_sel = m_sel | ns;
    m_dig = m_dig | nd;
  endtask

  // Drives one cycle of inputs at the falling edge and advances the model.
  // The task then returns the observed and expected frame_done, sampled 1 time unit after the rising edge.
  task automatic step(input logic [7:0] sel, input logic [63:0] seg, input logic clr,
                      output logic obs_done, output logic exp_done);
    @(negedge clk);
    seg_sel = sel;
    seg_out = seg;
    err_clr = clr;
    rd_addr = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1;
    model_apply(p_sel, p_seg, clr);
    p_sel = sel;
    p_seg = seg;
    obs_done = frame_done;
    exp_done = m_done;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; seg_sel = '0; seg_out = '0; err_clr = 1'b0; rd_addr = '0;
    model_reset();
    #12;
    checks++;
    if (d_status() !== 20'h0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got=%h done=%b want=00000 done=0", d_status(), frame_done);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd[%0d] got=%h want=00000000", a, rd_data);
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_one_sweep();
    logic od, ed;
    int done_at;
    done_at = -1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) step(8'(1 << k), enc(32'h11111111 * 32'(k)), 1'b0, od, ed);
      else       step(8'h00, 64'h0, 1'b0, od, ed);
      checks++;
      if (od !== ed) begin
        errors++;
        $display("FAIL sweep_done step=%0d got=%b want=%b", k, od, ed);
      end
      if (od === 1'b1 && done_at < 0) done_at = k;
    end
    checks++;
    if (done_at != 8) begin
      errors++;
      $display("FAIL sweep_latency got_step=%0d want_step=8", done_at);
    end
    rd_addr = 3'd3;
    #1;
    checks++;
    if (rd_data !== 32'h33333333 || frame_cnt !== 16'd1 || frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL sweep_result rd=%h cnt=%0d valid=%b want=33333333 1 1", rd_data, frame_cnt, frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic od, ed;
    logic [31:0] words [24];
    int pulses [$];
    logic [15:0] start_cnt;
    start_cnt = m_cnt;
    for (int k = 0; k < 24; k++) words[k] = $urandom;
    for (int k = 0; k < 26; k++) begin
      if (k < 24) step(8'(1 << (k % 8)), enc(words[k]), 1'b0, od, ed);
      else        step(8'h00, 64'h0, 1'b0, od, ed);
      checks++;
      if (od !== ed) begin
        errors++;
        $display("FAIL b2b_done step=%0d got=%b want=%b", k, od, ed);
      end
      if (od === 1'b1) pulses.push_back(k);
    end
    checks++;
    if (pulses.size() != 3 || pulses[0] != 8 || pulses[1] != 16 || pulses[2] != 24) begin
      errors++;
      $display("FAIL b2b_pulses got_count=%0d want=3 at steps 8,16,24", pulses.size());
    end
    checks++;
    if (frame_cnt !== start_cnt + 16'd3 || d_status() !== m_status()) begin
      errors++;
      $display("FAIL b2b_status got=%h want=%h", d_status(), m_status());
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== words[16 + a]) begin
        errors++;
        $display("FAIL b2b_rd[%0d] got=%h want=%h", a, rd_data, words[16 + a]);
      end
    end
  endtask

  task automatic test_order();
    logic od, ed;
    logic [31:0] saved [8];
    logic [31:0] w [8];
    int seen;
    for (int a = 0; a < 8; a++) saved[a] = m_commit[a];
    step(8'h01, enc(32'hA5A5A5A5), 1'b0, od, ed);
    step(8'h02, enc(32'h5A5A5A5A), 1'b0, od, ed);
    step(8'h08, enc(32'hDEADBEEF), 1'b0, od, ed);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      step(8'h00, 64'h0, 1'b0, od, ed);
      if (od === 1'b1) seen++;
    end
    checks++;
    if (seq_err !== 1'b1 || seen != 0 || d_status() !== m_status()) begin
      errors++;
      $display("FAIL order_err seq=%b pulses=%0d want seq=1 pulses=0", seq_err, seen);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== saved[a]) begin
        errors++;
        $display("FAIL order_keep[%0d] got=%h want=%h", a, rd_data, saved[a]);
      end
    end
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    seen = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) step(8'(1 << k), enc(w[k]), 1'b0, od, ed);
      else       step(8'h00, 64'h0, 1'b0, od, ed);
      if (od === 1'b1) seen++;
    end
    checks++;
    if (seen != 1 || d_status() !== m_status()) begin
      errors++;
      $display("FAIL order_recover pulses=%0d status=%h want 1 %h", seen, d_status(), m_status());
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== w[a]) begin
        errors++;
        $display("FAIL order_rd[%0d] got=%h want=%h", a, rd_data, w[a]);
      end
    end
  endtask

  task automatic test_illegal();
    logic od, ed;
    logic [63:0] bad;
    int seen;
    step(8'h03, enc(32'h12345678), 1'b0, od, ed);
    step(8'h00, 64'h0, 1'b0, od, ed);
    checks++;
    if (sel_err !== 1'b1 || d_status() !== m_status()) begin
      errors++;
      $display("FAIL illegal_sel got=%b want=1", sel_err);
    end
    bad = enc(32'h22222222);
    bad[7:0] = 8'h00;
    seen = 0;
    step(8'h01, enc(32'h00000000), 1'b0, od, ed);
    step(8'h02, enc(32'h11111111), 1'b0, od, ed);
    step(8'h04, bad, 1'b0, od, ed);
    for (int k = 3; k < 8; k++) begin
      step(8'(1 << k), enc(32'h01010101 * 32'(k)), 1'b0, od, ed);
      if (od === 1'b1) seen++;
    end
    step(8'h00, 64'h0, 1'b0, od, ed);
    if (od === 1'b1) seen++;
    checks++;
    if (dig_err !== 1'b1 || seen != 0 || d_status() !== m_status()) begin
      errors++;
      $display("FAIL illegal_dig dig=%b pulses=%0d want dig=1 pulses=0", dig_err, seen);
    end
    step(8'h00, 64'h0, 1'b1, od, ed);
    checks++;
    if ({seq_err, sel_err, dig_err} !== 3'b000) begin
      errors++;
      $display("FAIL illegal_clr got=%b want=000", {seq_err, sel_err, dig_err});
    end
    step(8'h01, bad, 1'b0, od, ed);
    step(8'h00, 64'h0, 1'b1, od, ed);
    checks++;
    if ({seq_err, sel_err, dig_err} !== 3'b001 || d_status() !== m_status()) begin
      errors++;
      $display("FAIL illegal_clr_race got=%b want=001", {seq_err, sel_err, dig_err});
    end
  endtask

  task automatic test_random();
    logic od, ed;
    logic [7:0] sel;
    logic [63:0] seg;
    logic clr;
    int gs, r;
    gs = 0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      seg = enc($urandom);
      if (r < 4) begin
        sel = 8'h00;
      end else if (r < 7) begin
        sel = 8'(3 << $urandom_range(0, 6));
      end else if (r < 10) begin
        sel = 8'(1 << $urandom_range(0, 7));
      end else begin
        sel = 8'(1 << gs);
        gs = (gs + 1) % 8;
        if (r < 13) seg[8*$urandom_range(0, 7) +: 8] = 8'($urandom);
      end
      clr = ($urandom_range(0, 19) == 0);
      step(sel, seg, clr, od, ed);
      checks++;
      if (od !== ed || d_status() !== m_status()) begin
        errors++;
        $display("FAIL random n=%0d done=%b status=%h want done=%b status=%h", n, od, d_status(), ed, m_status());
      end
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== m_commit[a]) begin
        errors++;
        $display("FAIL random_rd[%0d] got=%h want=%h", a, rd_data, m_commit[a]);
      end
    end
  endtask

  task automatic test_wrap();
    logic od, ed;
    int seen;
    step(8'h00, 64'h0, 1'b1, od, ed);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    seen = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) step(8'(1 << k), enc($urandom), 1'b0, od, ed);
      else       step(8'h00, 64'h0, 1'b0, od, ed);
      if (od === 1'b1) seen++;
    end
    checks++;
    if (frame_cnt !== 16'h0000 || seen != 1) begin
      errors++;
      $display("FAIL wrap_cnt got=%h pulses=%0d want=0000 pulses=1", frame_cnt, seen);
    end
  endtask

  task automatic test_reset_mid();
    logic od, ed;
    logic [31:0] w [8];
    int done_at;
    for (int k = 0; k < 5; k++) step(8'(1 << k), enc($urandom), 1'b0, od, ed);
    #2;
    n_rst = 1'b0;
    seg_sel = '0;
    seg_out = '0;
    #1;
    model_reset();
    checks++;
    if (d_status() !== 20'h0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_status got=%h done=%b want=00000 done=0", d_status(), frame_done);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== 32'h0) begin
        errors++;
        $display("FAIL midrst_rd[%0d] got=%h want=00000000", a, rd_data);
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    done_at = -1;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) step(8'(1 << k), enc(w[k]), 1'b0, od, ed);
      else       step(8'h00, 64'h0, 1'b0, od, ed);
      if (od === 1'b1 && done_at < 0) done_at = k;
    end
    checks++;
    if (done_at != 8 || frame_cnt !== 16'd1 || d_status() !== m_status()) begin
      errors++;
      $display("FAIL midrst_recover done_step=%0d cnt=%0d want step=8 cnt=1", done_at, frame_cnt);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== w[a]) begin
        errors++;
        $display("FAIL midrst_rd2[%0d] got=%h want=%h", a, rd_data, w[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_sweep();
    test_back_to_back();
    test_order();
    test_illegal();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time limit so that a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
